// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the prioritised interrupt controller: controller state
// encodings and a helper that sizes channel-index fields.
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_READY   = 2'b00,
        ST_DRAIN   = 2'b01,
        ST_JAL     = 2'b10,
        ST_SERVICE = 2'b11
    } ctrl_state_e;

    // Width of a channel index; a single-channel build still needs one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_pri_enc.sv
// Fixed-priority channel selector: reports whether any unmasked channel is
// pending and the lowest index among them.
module int_pri_enc
    import int_ctrl_pkg::*;
#(
    parameter  int NUM_CH = 8,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pend,
    input  logic [NUM_CH-1:0] mask,
    output logic              valid,
    output logic [CH_W-1:0]   idx
);

    logic [NUM_CH-1:0] cand_s;

    // Scan from the top down so the lowest eligible index is the last written.
    always_comb begin
        cand_s = pend & ~mask;
        valid  = |cand_s;
        idx    = {CH_W{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cand_s[i]) begin
                idx = CH_W'(i);
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/int_ctrl_pri.sv
// Prioritised interrupt controller: collects per-channel requests, selects the
// lowest unmasked pending channel, drains the pipeline with NOPs, inserts a JAL
// and holds service until the ISR returns.
module int_ctrl_pri
    import int_ctrl_pkg::*;
#(
    parameter  int NUM_CH  = 8,
    parameter  int NUM_W   = 16,
    parameter  int NOP_CNT = 4,
    localparam int CH_W    = ch_width(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset_b,
    input  logic                    halt,
    input  logic [NUM_CH-1:0]       int_req,
    input  logic [NUM_CH*NUM_W-1:0] int_num,
    input  logic [NUM_CH-1:0]       int_mask,
    input  logic                    nop_detect,
    input  logic                    int_done,
    output logic                    int_rdy,
    output logic                    idle,
    output logic                    jal_req,
    output logic                    int_srv_req,
    output logic [NUM_W-1:0]        int_srv_num,
    output logic [CH_W-1:0]         int_srv_ch,
    output logic [NUM_CH-1:0]       int_pend
);

    localparam logic [3:0] NOP_MAX = 4'(NOP_CNT);

    ctrl_state_e       state_r, state_s;
    logic [NUM_CH-1:0] pend_r, pend_s, clr_s;
    logic [NUM_W-1:0]  num_q_r [NUM_CH];
    logic [3:0]        nop_cnt_r, nop_cnt_s;
    logic [NUM_W-1:0]  srv_num_r;
    logic [CH_W-1:0]   srv_ch_r;
    logic              int_rdy_r, idle_r, jal_req_r, int_srv_req_r;
    logic              sel_valid_s;
    logic [CH_W-1:0]   sel_idx_s;
    logic              take_s;

    int_pri_enc #(
        .NUM_CH (NUM_CH)
    ) u_pri_enc (
        .pend  (pend_r),
        .mask  (int_mask),
        .valid (sel_valid_s),
        .idx   (sel_idx_s)
    );

    // Next-state and NOP-counter logic; halt freezes both.
    always_comb begin
        state_s   = state_r;
        nop_cnt_s = 4'd0;
        take_s    = 1'b0;
        if (halt) begin
            state_s   = state_r;
            nop_cnt_s = nop_cnt_r;
        end else begin
            case (state_r)
                ST_READY: begin
                    if (sel_valid_s) begin
                        state_s = ST_DRAIN;
                        take_s  = 1'b1;
                    end else begin
                        state_s = ST_READY;
                    end
                end
                ST_DRAIN: begin
                    if (nop_cnt_r == NOP_MAX) begin
                        state_s = ST_JAL;
                    end else begin
                        state_s   = ST_DRAIN;
                        nop_cnt_s = nop_cnt_r + {3'd0, nop_detect};
                    end
                end
                ST_JAL: begin
                    state_s = ST_SERVICE;
                end
                ST_SERVICE: begin
                    if (int_done) begin
                        state_s = ST_READY;
                    end else begin
                        state_s = ST_SERVICE;
                    end
                end
                default: begin
                    state_s = ST_READY;
                end
            endcase
        end
    end

    // Pending update: selection clears its bit, a new request on the same cycle wins.
    always_comb begin
        clr_s = {NUM_CH{1'b0}};
        if (take_s) begin
            clr_s[sel_idx_s] = 1'b1;
        end else begin
            clr_s = {NUM_CH{1'b0}};
        end
        pend_s = (pend_r & ~clr_s) | int_req;
    end

    // Control registers and decoded status outputs.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_r       <= ST_READY;
            pend_r        <= {NUM_CH{1'b0}};
            nop_cnt_r     <= 4'd0;
            srv_num_r     <= {NUM_W{1'b0}};
            srv_ch_r      <= {CH_W{1'b0}};
            int_rdy_r     <= 1'b1;
            idle_r        <= 1'b0;
            jal_req_r     <= 1'b0;
            int_srv_req_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            pend_r        <= pend_s;
            nop_cnt_r     <= nop_cnt_s;
            if (take_s) begin
                srv_num_r <= num_q_r[sel_idx_s];
                srv_ch_r  <= sel_idx_s;
            end
            int_rdy_r     <= (state_s == ST_READY);
            idle_r        <= (state_s == ST_DRAIN);
            jal_req_r     <= (state_s == ST_JAL);
            int_srv_req_r <= (state_s != ST_READY);
        end
    end

    // Per-channel interrupt number capture; latches even while halted.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            for (int i = 0; i < NUM_CH; i++) begin
                num_q_r[i] <= {NUM_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (int_req[i]) begin
                    num_q_r[i] <= int_num[i*NUM_W +: NUM_W];
                end
            end
        end
    end

    assign int_rdy     = int_rdy_r;
    assign idle        = idle_r;
    assign jal_req     = jal_req_r;
    assign int_srv_req = int_srv_req_r;
    assign int_srv_num = srv_num_r;
    assign int_srv_ch  = srv_ch_r;
    assign int_pend    = pend_r;

endmodule
